// File: rtl/fifo_stream_rd.sv
// Drain stage for a registered-read FIFO: pops words and presents them as a framed valid/ready stream.
// Optional statistics counters are compiled in with `define FIFO_RD_STATS_EN.
module fifo_stream_rd #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned PKT_LEN = 16
`ifdef FIFO_RD_STATS_EN
  ,
  parameter int unsigned STAT_WIDTH = 16
`endif
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_rddata_i,
  output logic              fifo_rd_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  input  logic              flush_i
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_words_o,
  output logic [STAT_WIDTH-1:0] stat_stall_o
`endif
);

  localparam int unsigned CWIDTH = $clog2(PKT_LEN) + 1;
  localparam logic [CWIDTH-1:0] LAST_BEAT = CWIDTH'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                rd_q, rd_d;
  logic                hs;

  assign hs = valid_q & m_ready_i;

  // State and output registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
    end
  end

  // Next state; the pop strobe is registered so it is high for exactly the SETTLE cycle,
  // one cycle after the empty flag was seen low with no pop in flight.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_i) state_d = SETTLE;
      end
      SETTLE: begin
        data_d  = fifo_rddata_i;
        state_d = VALID;
      end
      VALID: begin
        if (hs) begin
          cnt_d   = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CWIDTH'(1);
          state_d = fifo_empty_i ? IDLE : SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over a same-cycle handshake; any in-flight word is dropped
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    valid_d = (state_d == VALID);
    last_d  = valid_d && (cnt_d == LAST_BEAT);
    rd_d    = (state_d == SETTLE);
  end

  assign fifo_rd_o = rd_q;
  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;
  assign m_last_o  = last_q;

`ifdef FIFO_RD_STATS_EN
  logic [STAT_WIDTH-1:0] words_q, stall_q;

  // Saturating counters; cleared by reset only
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (hs && !flush_i && (words_q != '1)) words_q <= words_q + STAT_WIDTH'(1);
      if (valid_q && !m_ready_i && (stall_q != '1)) stall_q <= stall_q + STAT_WIDTH'(1);
    end
  end

  assign stat_words_o = words_q;
  assign stat_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Bench for fifo_stream_rd: registered-read FIFO model plus an in-order scoreboard with packet framing.
module tb_fifo_stream_rd;
  localparam int unsigned DW = 8;
  localparam int unsigned PL = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rddata = '0;
  logic          fifo_rd, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic          u1_rd, u1_valid, u1_last;
  logic [DW-1:0] u1_data;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]   stat_words, stat_stall, u1_sw, u1_ss;
`endif

  always #5 clk = ~clk;

  fifo_stream_rd #(.DWIDTH(DW), .PKT_LEN(PL)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .fifo_empty_i(fifo_empty), .fifo_rddata_i(fifo_rddata),
    .fifo_rd_o(fifo_rd), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_last_o(m_last), .flush_i(flush)
`ifdef FIFO_RD_STATS_EN
    , .stat_words_o(stat_words), .stat_stall_o(stat_stall)
`endif
  );

  // Single-beat packets: every valid beat must be last
  fifo_stream_rd #(.DWIDTH(DW), .PKT_LEN(1)) u1 (
    .clk_i(clk), .arst_n_i(arst_n), .fifo_empty_i(fifo_empty), .fifo_rddata_i(fifo_rddata),
    .fifo_rd_o(u1_rd), .m_data_o(u1_data), .m_valid_o(u1_valid), .m_ready_i(m_ready),
    .m_last_o(u1_last), .flush_i(flush)
`ifdef FIFO_RD_STATS_EN
    , .stat_words_o(u1_sw), .stat_stall_o(u1_ss)
`endif
  );

  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int            pops = 0;

  // FIFO with 1-cycle registered read; data is garbage unless the previous cycle was non-empty with no pop
  always @(posedge clk) begin
    if (mq.size() != 0 && !fifo_rd) fifo_rddata <= mq[0];
    else                            fifo_rddata <= DW'($urandom);
    if (fifo_rd) begin
      if (mq.size() != 0) void'(mq.pop_front());
      pops++;
    end
    if (push_en) begin
      mq.push_back(push_data);
      exp_q.push_back(push_data);
    end
    fifo_empty <= (mq.size() == 0);
  end

  int checks = 0, errors = 0;
  int cyc = 0, beat = 0, consumed = 0, run = 0, rd_count = 0, first_valid_cyc = -1;
  int ms = 0, mw = 0;
  bit flush_pend = 1'b0;
  logic prev_valid = 0, prev_ready = 0, prev_flush = 0, prev_rd = 0, prev_hs = 0, prev_u1_rd = 0;
  logic [DW-1:0] prev_data = '0;
  int            hs_cyc[$];
  logic [DW-1:0] hs_data[$];
  logic          hs_last[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Judges the current cycle (outputs plus the inputs just driven), then advances one clock
  task automatic tick();
    bit hs;
    if (flush_pend) begin
      while (consumed < pops) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        consumed++;
      end
      flush_pend = 1'b0;
    end
    hs = m_valid && m_ready && !flush && arst_n;
    chk("rd_while_empty", 32'(fifo_rd & fifo_empty), 0);
    chk("rd_back_to_back", 32'(fifo_rd & prev_rd), 0);
    chk("u1_rd_back_to_back", 32'(u1_rd & prev_u1_rd), 0);
    chk("u1_last", 32'(u1_last), 32'(u1_valid));
    if (prev_valid && !prev_ready && !prev_flush && arst_n) begin
      chk("hold_valid", 32'(m_valid), 1);
      chk("hold_data", 32'(m_data), 32'(prev_data));
    end
    if (prev_hs || prev_flush) chk("valid_gap", 32'(m_valid), 0);
    if (m_valid) chk("last", 32'(m_last), 32'(beat == PL - 1));
    else         chk("last_idle", 32'(m_last), 0);
    if (!m_valid && !fifo_empty && arst_n && !flush) run++;
    else run = 0;
    chk("starve_run", 32'(run > 2), 0);
`ifdef FIFO_RD_STATS_EN
    chk("stat_words", 32'(stat_words), 32'(mw));
    chk("stat_stall", 32'(stat_stall), 32'(ms));
    if (m_valid && !m_ready) ms++;
    if (hs) mw++;
`endif
    if (hs) begin
      chk("beat_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chk("data", 32'(m_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      consumed++;
      hs_cyc.push_back(cyc);
      hs_data.push_back(m_data);
      hs_last.push_back(m_last);
      beat = (beat + 1) % PL;
    end
    if (!arst_n || flush) begin
      beat = 0;
      flush_pend = 1'b1;
    end
    if (fifo_rd) rd_count++;
    if (m_valid && !prev_valid) first_valid_cyc = cyc;
    prev_valid = m_valid; prev_ready = m_ready; prev_flush = flush;
    prev_rd = fifo_rd; prev_u1_rd = u1_rd; prev_hs = hs; prev_data = m_data;
    cyc++;
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d);
    push_en = 1'b1;
    push_data = d;
    tick();
    push_en = 1'b0;
  endtask

  task automatic clear_logs();
    hs_cyc.delete(); hs_data.delete(); hs_last.delete();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 20) begin tick(); n++; end
    chk(tag, 32'(m_valid), 1);
  endtask

  initial begin
    int tw, rel, rd0;
    logic [9:0] lv;
    logic [DW-1:0] held;
    arst_n = 1'b0;
    @(negedge clk);
    // 1) reset with words already in the FIFO
    push(8'hA5);
    push(8'h5A);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_rd", 32'(fifo_rd), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", 32'(m_data), 0);
    tick();
    m_ready = 1'b1;
    arst_n = 1'b1;
    rel = -1;
    for (int i = 0; i < 8; i++) begin
      if (fifo_rd && rel < 0) rel = i;
      tick();
    end
    chk("t1_first_pop", 32'(rel), 1);
    for (int i = 0; i < 6; i++) tick();

    // 2) three words, ready high
    clear_logs();
    tw = cyc;
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_count", 32'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3) begin
      chk("t2_latency", 32'(hs_cyc[0] - tw), 3);
      chk("t2_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 2);
      chk("t2_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 2);
      chk("t2_d0", 32'(hs_data[0]), 32'h11);
      chk("t2_d1", 32'(hs_data[1]), 32'h22);
      chk("t2_d2", 32'(hs_data[2]), 32'h33);
    end

    // 3) framing restart, then 10 beats with PKT_LEN=4
    flush = 1'b1; tick(); flush = 1'b0;
    clear_logs();
    for (int i = 0; i < 10; i++) push(DW'(8'h40 + i));
    for (int i = 0; i < 30; i++) tick();
    chk("t3_count", 32'(hs_last.size()), 10);
    lv = '0;
    for (int i = 0; i < 10 && i < hs_last.size(); i++) lv[i] = hs_last[i];
    chk("t3_last_pattern", 32'(lv), 32'b0010001000);

    // 4) stall on beat 2, then beat 3 closes the packet
    m_ready = 1'b0;
    push(8'hA1); push(8'hB1);
    wait_valid("t4_valid");
    held = m_data;
    chk("t4_data", 32'(m_data), 32'hA1);
    chk("t4_last_a", 32'(m_last), 0);
`ifdef FIFO_RD_STATS_EN
    rd0 = int'(stat_stall);
`endif
    for (int i = 0; i < 5; i++) begin
      chk("t4_stable", 32'(m_data), 32'(held));
      chk("t4_no_pop", 32'(fifo_rd), 0);
      tick();
    end
`ifdef FIFO_RD_STATS_EN
    chk("t4_stall_cnt", 32'(int'(stat_stall) - rd0), 5);
`endif
    m_ready = 1'b1;
    tick();
    wait_valid("t4_valid_b");
    chk("t4_data_b", 32'(m_data), 32'hB1);
    chk("t4_last_b", 32'(m_last), 1);
    tick();

    // 5) flush on beat 2 of a packet
    clear_logs();
    push(8'hC1); push(8'hD1); push(8'hE1); push(8'hF1);
    for (int i = 0; i < 30 && !(m_valid && hs_data.size() == 2); i++) tick();
    chk("t5_on_beat2", 32'(m_valid && hs_data.size() == 2), 1);
    chk("t5_data_e", 32'(m_data), 32'hE1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_valid_off", 32'(m_valid), 0);
    wait_valid("t5_valid_f");
    chk("t5_data_f", 32'(m_data), 32'hF1);
    chk("t5_last_f", 32'(m_last), 0);

    // 6) drain, then a single word
    for (int i = 0; i < 20 && !(fifo_empty && !m_valid); i++) tick();
    chk("t6_drained", 32'(fifo_empty && !m_valid), 1);
    rd0 = rd_count;
    tw = cyc;
    push(8'h77);
    for (int i = 0; i < 8; i++) tick();
    chk("t6_one_pop", 32'(rd_count - rd0), 1);
    chk("t6_latency", 32'(first_valid_cyc - tw), 3);

    // Random traffic, ready and flush
    for (int i = 0; i < 1500; i++) begin
      push_en = ($urandom % 100) < 35;
      push_data = DW'($urandom);
      m_ready = ($urandom % 100) < 70;
      flush = ($urandom % 100) < 2;
      tick();
    end
    push_en = 1'b0; flush = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || m_valid); i++) tick();
    tick();
    chk("drain_all", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
